dense_network_scheduler: RTL and testbench

Time-multiplexes one `dense_layer` instance across `NUM_LAYERS` successive layers of a fully-connected network. It latches a network input vector and drives the shared layer's `inputs_ready`/`outputs_ready` handshake once per layer. It feeds each layer's outputs back as the next layer's inputs, and presents `layer_select` so the weight/bias store and activation mux serve the active layer. It sits between the top-level inference wrapper and the single `dense_layer` datapath.

---
 rtl/dense_network_scheduler_pkg.sv | 32 +++
 rtl/dense_network_scheduler_feature_buffer.sv | 30 +++
 rtl/dense_network_scheduler.sv | 124 ++++++++++++
 tb/tb_dense_network_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_network_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dense_network_scheduler_pkg
// Purpose  : Shared fixed-point, activation and scheduler state types.
// Revision : 1.0
// ============================================================================
package dense_network_scheduler_pkg;

   localparam int INTEGER_WIDTH  = 8;
   localparam int FRACTION_WIDTH = 8;
   localparam int FIXED_WIDTH    = INTEGER_WIDTH + FRACTION_WIDTH;

   typedef struct packed {
      logic [INTEGER_WIDTH-1:0]  integral;
      logic [FRACTION_WIDTH-1:0] fraction;
   } fixed_point_t;

   typedef enum logic [1:0] {
      ACT_NONE    = 2'd0,
      ACT_RELU    = 2'd1,
      ACT_SIGMOID = 2'd2
   } activation_type;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scheduler_state_t;

endpackage
`default_nettype wire

// File: rtl/dense_network_scheduler_feature_buffer.sv
`default_nettype none
// ============================================================================
// Module   : feature_buffer
// Purpose  : WIDTH-entry feature register bank, load-enabled, async clear.
// Revision : 1.0
// ============================================================================
module feature_buffer
   import dense_network_scheduler_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  fixed_point_t [WIDTH-1:0] load_data,
   output fixed_point_t [WIDTH-1:0] data
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_entry
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            data[i] <= '0;
         end else if (load) begin
            data[i] <= load_data[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dense_network_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dense_network_scheduler
// Purpose  : Sequences one shared dense_layer across NUM_LAYERS layers.
// Revision : 1.0
// ============================================================================
module dense_network_scheduler
   import dense_network_scheduler_pkg::*;
#(
   parameter int  NUM_LAYERS     = 3,
   parameter int  WIDTH          = 16,
   parameter int  TIMEOUT_CYCLES = 4096,
   localparam int SEL_W          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  fixed_point_t [WIDTH-1:0] network_inputs,
   output fixed_point_t [WIDTH-1:0] network_outputs,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout,
   output logic [SEL_W-1:0]         layer_select,
   output fixed_point_t [WIDTH-1:0] layer_inputs,
   output logic                     layer_inputs_ready,
   input  fixed_point_t [WIDTH-1:0] layer_outputs,
   input  logic                     layer_outputs_ready
);

   localparam int               WD_W       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_LAYER = SEL_W'(NUM_LAYERS - 1);

   scheduler_state_t         state;
   logic [WD_W-1:0]          watchdog;
   logic                     buffer_load;
   fixed_point_t [WIDTH-1:0] buffer_load_data;

   // The buffer is written only on an accepted start or on the first
   // completion sample in RUN, so it is stable for the whole of RUN/DRAIN.
   always_comb begin
      buffer_load      = 1'b0;
      buffer_load_data = layer_outputs;
      if (state == ST_IDLE && start) begin
         buffer_load      = 1'b1;
         buffer_load_data = network_inputs;
      end else if (state == ST_RUN && layer_outputs_ready) begin
         buffer_load      = 1'b1;
      end
   end

   feature_buffer #(
      .WIDTH     (WIDTH)
   ) u_feature_buffer (
      .clock     (clock),
      .reset     (reset),
      .load      (buffer_load),
      .load_data (buffer_load_data),
      .data      (layer_inputs)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state              <= ST_IDLE;
         busy               <= 1'b0;
         done               <= 1'b0;
         timeout            <= 1'b0;
         layer_inputs_ready <= 1'b0;
         layer_select       <= '0;
         watchdog           <= '0;
         network_outputs    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state              <= ST_RUN;
                  busy               <= 1'b1;
                  layer_inputs_ready <= 1'b1;
                  layer_select       <= '0;
                  timeout            <= 1'b0;
                  watchdog           <= '0;
               end
            end
            ST_RUN: begin
               watchdog <= watchdog + WD_W'(1);
               // Completion on the final watchdog cycle takes priority.
               if (layer_outputs_ready) begin
                  layer_inputs_ready <= 1'b0;
                  state              <= ST_DRAIN;
               end else if (watchdog == WD_LAST) begin
                  timeout            <= 1'b1;
                  layer_inputs_ready <= 1'b0;
                  busy               <= 1'b0;
                  state              <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!layer_outputs_ready) begin
                  if (layer_select == LAST_LAYER) begin
                     network_outputs <= layer_inputs;
                     done            <= 1'b1;
                     state           <= ST_DONE;
                  end else begin
                     layer_select       <= layer_select + SEL_W'(1);
                     watchdog           <= '0;
                     layer_inputs_ready <= 1'b1;
                     state              <= ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dense_network_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_network_scheduler
// Purpose  : Self-checking bench with a latency-programmable dense_layer stub.
// Revision : 1.0
// ============================================================================
module tb_dense_network_scheduler;
   import dense_network_scheduler_pkg::*;

   localparam int NL  = 3;
   localparam int W   = 16;
   localparam int FPW = FIXED_WIDTH;
   localparam int VW  = W * FPW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [VW-1:0] network_inputs = '0;
   logic [VW-1:0] network_outputs;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [1:0]    layer_select;
   logic [VW-1:0] layer_inputs;
   logic          layer_inputs_ready;
   logic [VW-1:0] layer_outputs;
   logic          layer_outputs_ready;

   int total = 0;
   int bad   = 0;

   // Stub configuration: mode 0 = +1 LSB, 1 = RELU(0*x - 1.0) = 0, 2 = never completes.
   int stub_lat  = 5;
   int stub_mode = 0;
   int stub_hold = 0;
   int stub_cnt;
   int stub_hold_left;
   logic stub_ready;

   always #5 clock = ~clock;

   dense_network_scheduler #(
      .NUM_LAYERS          (NL),
      .WIDTH               (W),
      .TIMEOUT_CYCLES      (8)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .network_inputs      (network_inputs),
      .network_outputs     (network_outputs),
      .busy                (busy),
      .done                (done),
      .timeout             (timeout),
      .layer_select        (layer_select),
      .layer_inputs        (layer_inputs),
      .layer_inputs_ready  (layer_inputs_ready),
      .layer_outputs       (layer_outputs),
      .layer_outputs_ready (layer_outputs_ready)
   );

   // Outputs are scrambled during the hold window so any late re-capture shows up.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stub_ready     <= 1'b0;
         stub_cnt       <= 0;
         stub_hold_left <= 0;
         layer_outputs  <= '0;
      end else if (layer_inputs_ready) begin
         if (!stub_ready && stub_mode != 2) begin
            if (stub_cnt == stub_lat - 1) begin
               stub_ready     <= 1'b1;
               stub_hold_left <= stub_hold;
               for (int j = 0; j < W; j++)
                  layer_outputs[j*FPW +: FPW] <= (stub_mode == 1) ? '0 : layer_inputs[j*FPW +: FPW] + 16'd1;
            end else begin
               stub_cnt <= stub_cnt + 1;
            end
         end
      end else begin
         stub_cnt <= 0;
         if (stub_ready) begin
            if (stub_hold_left != 0) begin
               stub_hold_left <= stub_hold_left - 1;
               for (int j = 0; j < W; j++)
                  layer_outputs[j*FPW +: FPW] <= layer_outputs[j*FPW +: FPW] + 16'h0100;
            end else begin
               stub_ready <= 1'b0;
            end
         end
      end
   end

   assign layer_outputs_ready = stub_ready && (layer_inputs_ready || stub_hold_left != 0);

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] base;
      int          lat;
      int          mode;
      int          hold;
      int          cyc;
      bit          extra;
   } vec_t;

   logic [VW-1:0] exp_q[$];
   int            sel_q[$];

   task automatic run_inference(input vec_t t);
      logic [VW-1:0] v, e, li, got;
      int cyc, ndone, done_cyc, layer;
      logic prev_lir;
      stub_lat  = t.lat;
      stub_mode = t.mode;
      stub_hold = t.hold;
      for (int j = 0; j < W; j++) begin
         v[j*FPW +: FPW] = t.base + 16'(3 * j);
         e[j*FPW +: FPW] = (t.mode == 1) ? 16'd0 : t.base + 16'(3 * j) + 16'(NL);
      end
      exp_q.push_back(e);
      for (int l = 0; l < NL; l++) sel_q.push_back(l);
      got = '0;
      @(negedge clock);
      network_inputs = v;
      start = 1'b1;
      @(posedge clock);
      cyc = 0; ndone = 0; done_cyc = -1; prev_lir = 1'b0; layer = 0;
      while (cyc < t.cyc + 30) begin
         @(negedge clock);
         cyc++;
         start = t.extra && (cyc == 3 || cyc == 10);
         if (t.extra) network_inputs = ~v;
         if (cyc == 1) begin
            check("busy_c1", VW'(busy), VW'(1));
            check("lir_c1", VW'(layer_inputs_ready), VW'(1));
            check("timeout_c1", VW'(timeout), VW'(0));
         end
         if (layer_inputs_ready && !prev_lir) begin
            for (int j = 0; j < W; j++)
               li[j*FPW +: FPW] = (t.mode == 1) ? ((layer == 0) ? v[j*FPW +: FPW] : 16'd0)
                                                : v[j*FPW +: FPW] + 16'(layer);
            check("layer_inputs", layer_inputs, li);
            if (sel_q.size() == 0) check("extra_run", VW'(1), VW'(0));
            else check("layer_select", VW'(layer_select), VW'(sel_q.pop_front()));
            layer++;
         end
         prev_lir = layer_inputs_ready;
         if (done) begin
            ndone++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               got = exp_q.pop_front();
               check("network_outputs", network_outputs, got);
            end
         end
      end
      check("done_cycle", VW'(done_cyc), VW'(t.cyc));
      check("done_count", VW'(ndone), VW'(1));
      check("layers_seen", VW'(sel_q.size()), VW'(0));
      check("outputs_hold", network_outputs, e);
      sel_q.delete();
      exp_q.delete();
   endtask

   initial begin
      vec_t tbl[5];
      vec_t norm;
      logic [VW-1:0] prev_out;
      int cyc, ndone;

      tbl[0] = '{base: 16'h0040, lat: 5, mode: 0, hold: 0, cyc: 22, extra: 1'b0};
      tbl[1] = '{base: 16'hFFFF, lat: 1, mode: 0, hold: 0, cyc: 10, extra: 1'b0};
      tbl[2] = '{base: 16'h7FFE, lat: 3, mode: 0, hold: 2, cyc: 22, extra: 1'b0};
      tbl[3] = '{base: 16'h1234, lat: 2, mode: 1, hold: 0, cyc: 13, extra: 1'b0};
      tbl[4] = '{base: 16'h0040, lat: 5, mode: 0, hold: 0, cyc: 22, extra: 1'b1};
      norm   = '{base: 16'h0100, lat: 5, mode: 0, hold: 0, cyc: 22, extra: 1'b0};

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_busy", VW'(busy), VW'(0));
      check("rst_done", VW'(done), VW'(0));
      check("rst_timeout", VW'(timeout), VW'(0));
      check("rst_lir", VW'(layer_inputs_ready), VW'(0));
      check("rst_sel", VW'(layer_select), VW'(0));
      check("rst_layer_inputs", layer_inputs, '0);
      check("rst_net_out", network_outputs, '0);

      for (int i = 0; i < 5; i++) run_inference(tbl[i]);

      // Watchdog: layer never completes.
      prev_out  = network_outputs;
      stub_mode = 2;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      cyc = 0; ndone = 0;
      while (cyc < 20) begin
         @(negedge clock);
         cyc++;
         start = 1'b0;
         if (done) ndone++;
         if (cyc == 8) check("wd_timeout_c8", VW'(timeout), VW'(0));
         if (cyc == 9) begin
            check("wd_timeout_c9", VW'(timeout), VW'(1));
            check("wd_busy_c9", VW'(busy), VW'(0));
            check("wd_lir_c9", VW'(layer_inputs_ready), VW'(0));
         end
      end
      check("wd_no_done", VW'(ndone), VW'(0));
      check("wd_outputs_kept", network_outputs, prev_out);
      check("wd_timeout_sticky", VW'(timeout), VW'(1));
      run_inference(norm);

      // Reset in the middle of layer 1.
      stub_mode = 0; stub_lat = 5; stub_hold = 0;
      @(negedge clock);
      network_inputs = '1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!(layer_select == 2'd1 && layer_inputs_ready) && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      check("mid_reached_layer1", VW'(cyc < 50), VW'(1));
      #1 reset = 1'b1;
      #1;
      check("mid_busy", VW'(busy), VW'(0));
      check("mid_lir", VW'(layer_inputs_ready), VW'(0));
      check("mid_sel", VW'(layer_select), VW'(0));
      check("mid_layer_inputs", layer_inputs, '0);
      check("mid_net_out", network_outputs, '0);
      @(negedge clock);
      reset = 1'b0;
      run_inference(tbl[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
